decoder_layer_scheduler: RTL and testbench

- Sequences the contextual decoder's eight convolution ops (UP1, UP2, RES1a, RES1b, UP3, RES2a, RES2b, UP4) over one shared conv engine.
- For each op it streams that op's weights and bias from weight memory into the engine weight buffer.
- It then configures the engine (op id, cin, cout, concat select, residual add), pulses engine start and waits for engine done.
- Sits between the top-level start/done interface and the conv engine plus weight SRAM.

---
 rtl/decoder_layer_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_decoder_layer_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_layer_scheduler.sv
// Sequences the eight contextual-decoder convolution ops over one shared conv engine:
// stream each op's weights/bias into the engine buffer, configure the engine, start it, await done.
module decoder_layer_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNEL_N  = 4,
    parameter int CHANNEL_M  = 6,
    parameter int OUT_CH     = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            cur_op,
    output logic                  wt_rd_en,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic                  wt_rd_valid,
    input  logic [DATA_WIDTH-1:0] wt_rd_data,
    input  logic                  wt_ready,
    output logic                  wt_buf_we,
    output logic [15:0]           wt_buf_idx,
    output logic [DATA_WIDTH-1:0] wt_buf_data,
    output logic                  eng_start,
    output logic [2:0]            eng_op,
    output logic [7:0]            eng_cin,
    output logic [7:0]            eng_cout,
    output logic [1:0]            concat_sel,
    output logic                  res_add,
    input  logic                  eng_done
);

    // Counters are one bit wider than the address so "issued == words" is representable,
    // and at least 17 bits so the 16-bit buffer index can always be sliced out.
    localparam int CNT_W = (ADDR_WIDTH >= 16) ? ADDR_WIDTH + 1 : 17;

    function automatic int op_cin(input int op);
        case (op)
            0:       return CHANNEL_M;
            1, 3, 6: return CHANNEL_N;
            default: return 2 * CHANNEL_N;
        endcase
    endfunction

    function automatic int op_cout(input int op);
        case (op)
            0, 1, 4: return 4 * CHANNEL_N;
            2, 5:    return CHANNEL_N;
            3, 6:    return 2 * CHANNEL_N;
            default: return OUT_CH;
        endcase
    endfunction

    // 3x3 kernels for every (cout, cin) pair followed by one bias word per output channel
    function automatic int op_words(input int op);
        return op_cout(op) * op_cin(op) * 9 + op_cout(op);
    endfunction

    function automatic int op_base(input int op);
        int acc;
        acc = 0;
        for (int i = 0; i < op; i++) begin
            acc += op_words(i);
        end
        return acc;
    endfunction

    function automatic int op_concat(input int op);
        case (op)
            2:       return 1;
            5:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic op_res(input int op);
        return (op == 3) || (op == 6);
    endfunction

    logic [CNT_W-1:0]      words_tab  [8];
    logic [ADDR_WIDTH-1:0] base_tab   [8];
    logic [7:0]            cin_tab    [8];
    logic [7:0]            cout_tab   [8];
    logic [1:0]            concat_tab [8];
    logic                  res_tab    [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_op_tab
        assign words_tab[gi]  = CNT_W'(op_words(gi));
        assign base_tab[gi]   = ADDR_WIDTH'(op_base(gi));
        assign cin_tab[gi]    = 8'(op_cin(gi));
        assign cout_tab[gi]   = 8'(op_cout(gi));
        assign concat_tab[gi] = 2'(op_concat(gi));
        assign res_tab[gi]    = op_res(gi);
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CFG,
        ST_WAIT,
        ST_FIN
    } state_t;

    state_t                state_reg, state_next;
    logic [2:0]            cur_op_reg, cur_op_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg;
    logic                  clear_cnt;
    logic [CNT_W-1:0]      issued_reg;
    logic [CNT_W-1:0]      returned_reg;
    logic                  buf_we_reg;
    logic [15:0]           buf_idx_reg;
    logic [DATA_WIDTH-1:0] buf_data_reg;
    logic                  eng_start_reg;
    logic [2:0]            eng_op_reg;
    logic [7:0]            eng_cin_reg;
    logic [7:0]            eng_cout_reg;
    logic [1:0]            concat_sel_reg;
    logic                  res_add_reg;

    logic [CNT_W-1:0]      words_cur;
    logic [ADDR_WIDTH-1:0] base_cur;
    logic                  in_load;
    logic                  issue_req;
    logic                  ret_accept;
    logic                  load_to_cfg;

    assign words_cur   = words_tab[cur_op_reg];
    assign base_cur    = base_tab[cur_op_reg];
    assign in_load     = (state_reg == ST_LOAD);
    assign issue_req   = in_load && (issued_reg < words_cur) && wt_ready;
    // Returns beyond the op's word count are dropped so a stray beat cannot push the index past the op
    assign ret_accept  = in_load && wt_rd_valid && (returned_reg < words_cur);
    assign load_to_cfg = in_load && (state_next == ST_CFG);

    always_comb begin
        state_next  = state_reg;
        cur_op_next = cur_op_reg;
        busy_next   = busy_reg;
        clear_cnt   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_LOAD;
                    busy_next   = 1'b1;
                    cur_op_next = 3'd0;
                    clear_cnt   = 1'b1;
                end
            end
            ST_LOAD: begin
                // returned reaches words on the same edge that registers the final buffer write
                if (returned_reg == words_cur) begin
                    state_next = ST_CFG;
                end
            end
            ST_CFG: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    if (cur_op_reg == 3'd7) begin
                        state_next = ST_FIN;
                        busy_next  = 1'b0;
                    end else begin
                        state_next  = ST_LOAD;
                        cur_op_next = cur_op_reg + 3'd1;
                        clear_cnt   = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            cur_op_reg <= 3'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cur_op_reg <= cur_op_next;
            busy_reg   <= busy_next;
            done_reg   <= (state_reg == ST_WAIT) && (state_next == ST_FIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_reg   <= '0;
            returned_reg <= '0;
            buf_we_reg   <= 1'b0;
            buf_idx_reg  <= '0;
            buf_data_reg <= '0;
        end else begin
            if (clear_cnt) begin
                issued_reg   <= '0;
                returned_reg <= '0;
            end else begin
                if (issue_req) begin
                    issued_reg <= issued_reg + CNT_W'(1);
                end
                if (ret_accept) begin
                    returned_reg <= returned_reg + CNT_W'(1);
                end
            end
            buf_we_reg <= ret_accept;
            if (ret_accept) begin
                buf_idx_reg  <= returned_reg[15:0];
                buf_data_reg <= wt_rd_data;
            end
        end
    end

    // Configuration is latched on entry to CFG and held through WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_start_reg  <= 1'b0;
            eng_op_reg     <= 3'd0;
            eng_cin_reg    <= 8'd0;
            eng_cout_reg   <= 8'd0;
            concat_sel_reg <= 2'd0;
            res_add_reg    <= 1'b0;
        end else begin
            eng_start_reg <= load_to_cfg;
            if (load_to_cfg) begin
                eng_op_reg     <= cur_op_reg;
                eng_cin_reg    <= cin_tab[cur_op_reg];
                eng_cout_reg   <= cout_tab[cur_op_reg];
                concat_sel_reg <= concat_tab[cur_op_reg];
                res_add_reg    <= res_tab[cur_op_reg];
            end
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign cur_op      = cur_op_reg;
    assign wt_rd_en    = issue_req;
    assign wt_addr     = issue_req ? (base_cur + issued_reg[ADDR_WIDTH-1:0]) : '0;
    assign wt_buf_we   = buf_we_reg;
    assign wt_buf_idx  = buf_idx_reg;
    assign wt_buf_data = buf_data_reg;
    assign eng_start   = eng_start_reg;
    assign eng_op      = eng_op_reg;
    assign eng_cin     = eng_cin_reg;
    assign eng_cout    = eng_cout_reg;
    assign concat_sel  = concat_sel_reg;
    assign res_add     = res_add_reg;

endmodule

// File: tb/tb_decoder_layer_scheduler.sv
// Scoreboard bench for decoder_layer_scheduler: a weight-memory model queues expected buffer
// writes per accepted read, and a monitor checks writes and engine configuration as they appear.
module tb_decoder_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [2:0]  cur_op;
    logic        wt_rd_en;
    logic [15:0] wt_addr;
    logic        wt_rd_valid = 1'b0;
    logic [15:0] wt_rd_data = 16'h0;
    logic        wt_ready = 1'b0;
    logic        wt_buf_we;
    logic [15:0] wt_buf_idx;
    logic [15:0] wt_buf_data;
    logic        eng_start;
    logic [2:0]  eng_op;
    logic [7:0]  eng_cin, eng_cout;
    logic [1:0]  concat_sel;
    logic        res_add;
    logic        eng_done = 1'b0;

    decoder_layer_scheduler #(
        .DATA_WIDTH(16), .CHANNEL_N(4), .CHANNEL_M(6), .OUT_CH(128), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .cur_op(cur_op),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rd_valid(wt_rd_valid),
        .wt_rd_data(wt_rd_data), .wt_ready(wt_ready), .wt_buf_we(wt_buf_we),
        .wt_buf_idx(wt_buf_idx), .wt_buf_data(wt_buf_data), .eng_start(eng_start),
        .eng_op(eng_op), .eng_cin(eng_cin), .eng_cout(eng_cout), .concat_sel(concat_sel),
        .res_add(res_add), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    // Hand-computed op table for N=4, M=6, OUT_CH=128
    int exp_words [8] = '{880, 592, 292, 296, 1168, 292, 296, 9344};
    int exp_base  [8] = '{0, 880, 1472, 1764, 2060, 3228, 3520, 3816};
    int exp_cin   [8] = '{6, 4, 8, 4, 8, 8, 4, 8};
    int exp_cout  [8] = '{16, 16, 4, 8, 16, 4, 8, 128};
    int exp_cat   [8] = '{0, 0, 1, 0, 0, 2, 0, 0};
    int exp_res   [8] = '{0, 0, 0, 1, 0, 0, 1, 0};

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int mq_addr [$];
    int mq_due  [$];
    bit rand_mode = 1'b0;

    int sb_idx  [$];
    int sb_data [$];
    bit track = 1'b0;
    bit first_req = 1'b0;
    int run_starts = 0;
    int wr_count = 0;
    int max_addr = 0;
    int done_cnt = 0;
    int eng_cnt = 0;
    bit spurious_req = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int mem_word(input int a);
        logic [15:0] t;
        t = a[15:0];
        return int'({t[7:0], t[15:8]} ^ 16'h5A3C);
    endfunction

    // Weight memory: in-order responses with fixed 2-cycle or random 1-4 cycle latency
    always @(negedge clk) begin
        int lat;
        int a;
        cyc++;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            wt_rd_valid = 1'b1;
            wt_rd_data  = 16'(mem_word(mq_addr[0]));
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            wt_rd_valid = 1'b0;
            wt_rd_data  = 16'hDEAD;
        end
        wt_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (wt_rd_en && wt_ready) begin
            a   = int'(wt_addr);
            lat = rand_mode ? int'($urandom_range(1, 4)) : 2;
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat);
            if (track && run_starts < 8) begin
                if (first_req) begin
                    chk($sformatf("first_addr_op%0d", run_starts), a, exp_base[run_starts]);
                    first_req = 1'b0;
                end
                sb_idx.push_back(a - exp_base[run_starts]);
                sb_data.push_back(mem_word(a));
                if (a > max_addr) max_addr = a;
            end
        end
    end

    // Engine: done pulse 5 cycles after start, plus an optional one-off spurious pulse
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!rst) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done = 1'b1;
            end
            if (eng_start) eng_cnt = 4;
            if (spurious_req) begin
                eng_done     = 1'b1;
                spurious_req = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (wt_buf_we) begin
                if (sb_idx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_write: idx=%0d data=%h with no outstanding read (t=%0t)",
                             wt_buf_idx, wt_buf_data, $time);
                end else begin
                    chk("buf_idx", int'(wt_buf_idx), sb_idx.pop_front());
                    chk("buf_data", int'(wt_buf_data), sb_data.pop_front());
                end
                wr_count++;
            end
            if (eng_start) begin
                if (run_starts < 8) begin
                    $display("op%0d start: cin=%0d cout=%0d concat=%0d res=%0d writes=%0d",
                             run_starts, eng_cin, eng_cout, concat_sel, res_add, wr_count);
                    chk("eng_op", int'(eng_op), run_starts);
                    chk("eng_cin", int'(eng_cin), exp_cin[run_starts]);
                    chk("eng_cout", int'(eng_cout), exp_cout[run_starts]);
                    chk("concat_sel", int'(concat_sel), exp_cat[run_starts]);
                    chk("res_add", int'(res_add), exp_res[run_starts]);
                    chk("op_words", wr_count, exp_words[run_starts]);
                    chk("writes_pending_at_start", sb_idx.size(), 0);
                    chk("busy_in_op", int'(busy), 1);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_eng_start: start #%0d, expected 8 (t=%0t)", run_starts + 1, $time);
                end
                run_starts++;
                wr_count  = 0;
                first_req = 1'b1;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cur_op"}, int'(cur_op), 0);
        chk({tag, "_wt_rd_en"}, int'(wt_rd_en), 0);
        chk({tag, "_wt_addr"}, int'(wt_addr), 0);
        chk({tag, "_wt_buf_we"}, int'(wt_buf_we), 0);
        chk({tag, "_wt_buf_idx"}, int'(wt_buf_idx), 0);
        chk({tag, "_wt_buf_data"}, int'(wt_buf_data), 0);
        chk({tag, "_eng_start"}, int'(eng_start), 0);
        chk({tag, "_eng_op"}, int'(eng_op), 0);
        chk({tag, "_eng_cin"}, int'(eng_cin), 0);
        chk({tag, "_eng_cout"}, int'(eng_cout), 0);
        chk({tag, "_concat_sel"}, int'(concat_sel), 0);
        chk({tag, "_res_add"}, int'(res_add), 0);
    endtask

    task automatic start_seq();
        run_starts = 0;
        wr_count   = 0;
        first_req  = 1'b1;
        max_addr   = 0;
        done_cnt   = 0;
        sb_idx.delete();
        sb_data.delete();
        track = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic finish_seq(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt, 1);
        repeat (4) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("op_count", run_starts, 8);
        chk("busy_after_done", int'(busy), 0);
        chk("last_addr", max_addr, 13159);
        chk("outstanding_writes", sb_idx.size(), 0);
        $display("sequence end: starts=%0d done_pulses=%0d last_addr=%0d", run_starts, done_cnt, max_addr);
    endtask

    task automatic wait_point(input int op, input int writes, input int budget);
        int n;
        n = 0;
        while (!(run_starts == op && wr_count >= writes) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_op%0d", op), run_starts, op);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("in_reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("after_reset");

        // Full sequence, always-ready memory, 2-cycle latency
        rand_mode = 1'b0;
        start_seq();
        finish_seq(20000);

        // Random ready stalls and 1-4 cycle latency
        rand_mode = 1'b1;
        start_seq();
        finish_seq(50000);
        rand_mode = 1'b0;
        repeat (10) @(negedge clk);

        // Spurious eng_done while loading op1, extra start during op3
        start_seq();
        wait_point(1, 100, 5000);
        spurious_req = 1'b1;
        wait_point(3, 50, 10000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_seq(20000);

        // Asynchronous reset in the middle of op4's load
        start_seq();
        wait_point(4, 300, 10000);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        track = 1'b0;
        sb_idx.delete();
        sb_data.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_idle_after_reset", int'(busy), 0);
        chk("cur_op_after_reset", int'(cur_op), 0);

        // Fresh run from op0 after the reset
        start_seq();
        finish_seq(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
